// File: rtl/button_conditioner_n_pkg.sv
// Shared channel state encoding, controller channel indices and default timing
// for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2,
    ST_DEB_REL   = 2'd3
  } btn_state_e;

  localparam int JOGAR    = 0;
  localparam int CONFIRMA = 1;
  localparam int RESET_BTN = 2;
  localparam int DIREITA  = 3;
  localparam int ESQUERDA = 4;
  localparam int BOTAO0   = 5;
  localparam int BOTAO1   = 6;
  localparam int BOTAO2   = 7;
  localparam int BOTAO3   = 8;

  localparam int DEF_N_CH            = 9;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  function automatic logic is_held(input btn_state_e st);
    return (st == ST_HELD) || (st == ST_DEB_REL);
  endfunction

endpackage

// File: rtl/button_conditioner_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM with counter, and the
// auto-repeat counter when BTN_AUTOREPEAT_EN is defined.
module button_conditioner_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
`ifdef BTN_AUTOREPEAT_EN
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
`endif
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  btn_state_e       state, state_nxt;
  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s, level_nxt, press_nxt, release_nxt, rpt_nxt;

  // Sampled value already in active-high terms.
  assign s         = sync[1] ^ ACTIVE_LOW;
  assign level_nxt = is_held(state_nxt);

  // Synchroniser, FSM state, debounce counter and registered pulses
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync          <= {2{ACTIVE_LOW}};
      state         <= ST_IDLE;
      cnt           <= CNT_ZERO;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync          <= {sync[0], raw};
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      level         <= level_nxt;
      press         <= press_nxt | rpt_nxt;
      release_pulse <= release_nxt;
    end
  end

  // Debounce next-state: any disagreeing sample restarts the count
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s) begin
          state_nxt = ST_DEB_PRESS;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = CNT_ZERO;
        end
      end
      ST_DEB_PRESS: begin
        if (!s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HELD;
          cnt_nxt   = CNT_ZERO;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_nxt = ST_DEB_REL;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = CNT_ZERO;
        end
      end
      ST_DEB_REL: begin
        if (s) begin
          state_nxt = ST_HELD;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = ST_IDLE;
          cnt_nxt     = CNT_ZERO;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_ZERO   = {RPT_W{1'b0}};
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rcnt, rcnt_nxt;
  logic             rfirst, rfirst_nxt;

  // Repeat counter state and registered repeat pulse
  always_ff @(posedge clock) begin
    if (!reset) begin
      rcnt         <= RPT_ZERO;
      rfirst       <= 1'b1;
      repeat_pulse <= 1'b0;
    end else begin
      rcnt         <= rcnt_nxt;
      rfirst       <= rfirst_nxt;
      repeat_pulse <= rpt_nxt;
    end
  end

  // Counter restarts at the press; a release edge wins over a due repeat
  always_comb begin
    rcnt_nxt   = rcnt;
    rfirst_nxt = rfirst;
    rpt_nxt    = 1'b0;
    if (press_nxt) begin
      rcnt_nxt   = RPT_ZERO;
      rfirst_nxt = 1'b1;
    end else if (level && level_nxt) begin
      if ((rfirst && (rcnt == RPT_DELAY)) || (!rfirst && (rcnt == RPT_PERIOD))) begin
        rpt_nxt    = 1'b1;
        rcnt_nxt   = RPT_ZERO;
        rfirst_nxt = 1'b0;
      end else begin
        rcnt_nxt = rcnt + RPT_ONE;
      end
    end else begin
      rcnt_nxt   = RPT_ZERO;
      rfirst_nxt = 1'b1;
    end
  end
`else
  assign rpt_nxt      = 1'b0;
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner_n.sv
// N-channel push-button conditioner: per-channel debounce, enable gating and
// lowest-index press encoder. Auto-repeat is built when BTN_AUTOREPEAT_EN is defined.
module button_conditioner_n
  import btn_pkg::*;
#(
  parameter int              N_CH            = DEF_N_CH,
  parameter int              DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int              CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter logic [N_CH-1:0] ACTIVE_LOW_MASK = {N_CH{1'b0}},
  parameter int              REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int              REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [N_CH-1:0]                            btn_raw,
  input  logic [N_CH-1:0]                            en_mask,
  output logic [N_CH-1:0]                            level,
  output logic [N_CH-1:0]                            press,
  output logic [N_CH-1:0]                            release_pulse,
  output logic [N_CH-1:0]                            repeat_pulse,
  output logic                                       press_any,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] press_idx
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] ch_press, ch_release, ch_repeat;

  if ((DEBOUNCE_CYCLES < 2) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_params
    $error("button_conditioner_n: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_conditioner_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
`ifdef BTN_AUTOREPEAT_EN
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
`endif
      .ACTIVE_LOW     (ACTIVE_LOW_MASK[i])
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .raw          (btn_raw[i]),
      .level        (level[i]),
      .press        (ch_press[i]),
      .release_pulse(ch_release[i]),
      .repeat_pulse (ch_repeat[i])
    );
  end

  // Disabled channels still track level; only their pulses are suppressed.
  assign press         = ch_press & en_mask;
  assign release_pulse = ch_release & en_mask;
  assign repeat_pulse  = ch_repeat & en_mask;
  assign press_any     = |press;

  // Lowest-index encoder: scanning downward lets channel 0 win
  always_comb begin
    press_idx = {IDX_W{1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (press[i]) begin
        press_idx = IDX_W'(i);
      end else begin
        press_idx = press_idx;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner_n.sv
// Scoreboard bench for button_conditioner_n: a cycle model built on
// "N consecutive disagreeing samples flip the level" feeds an expectation queue.
module tb_button_conditioner_n;

  localparam int N_CH = 4;
  localparam int DC   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam logic [3:0] ALM = 4'b1000;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] btn_raw, en_mask;
  logic [3:0] level, press, release_pulse, repeat_pulse;
  logic       press_any;
  logic [1:0] press_idx;

  always #5 clock = ~clock;

  button_conditioner_n #(
    .N_CH(N_CH), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW_MASK(ALM),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .en_mask(en_mask),
    .level(level), .press(press), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .press_any(press_any), .press_idx(press_idx)
  );

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rpt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  logic [3:0] m_sync1, m_sync2, m_level;
  int m_run [4];
  int m_hold[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_update(output exp_t e);
    logic [3:0] s, p, r, rp;
    p = 4'b0; r = 4'b0; rp = 4'b0;
    if (!reset) begin
      m_sync1 = ALM; m_sync2 = ALM; m_level = 4'b0;
      for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_hold[i] = 0; end
    end else begin
      s = m_sync2 ^ ALM;
      m_sync2 = m_sync1;
      m_sync1 = btn_raw;
      for (int i = 0; i < 4; i++) begin
        if (s[i] != m_level[i]) m_run[i]++; else m_run[i] = 0;
        if (m_run[i] == DC) begin
          m_level[i] = ~m_level[i];
          m_run[i]   = 0;
          m_hold[i]  = 0;
          if (m_level[i]) p[i] = 1'b1; else r[i] = 1'b1;
        end else if (m_level[i]) begin
          m_hold[i]++;
`ifdef BTN_AUTOREPEAT_EN
          if (m_hold[i] == RD || (m_hold[i] > RD && (m_hold[i] - RD) % RP == 0)) rp[i] = 1'b1;
`endif
        end
      end
    end
    e.level = m_level;
    e.press = (p | rp) & en_mask;
    e.rel   = r & en_mask;
    e.rpt   = rp & en_mask;
  endtask

  // One clock: model consumes the inputs the DUT samples, then inputs may change at negedge+1.
  task automatic step();
    exp_t e;
    @(posedge clock);
    model_update(e);
    exp_q.push_back(e);
    @(negedge clock);
    #1;
  endtask

  task automatic wait_pulse(input int ch, input bit rel, output int n);
    n = -1;
    for (int k = 1; k <= 20 && n < 0; k++) begin
      step();
      if ((rel ? release_pulse[ch] : press[ch]) === 1'b1) n = k;
    end
  endtask

  // Monitor: compare every presented output cycle against the queued expectation
  always @(negedge clock) begin
    exp_t e;
    logic [1:0] idx;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) if (e.press[i]) idx = 2'(i);
      chk("level", 32'(level), 32'(e.level));
      chk("press", 32'(press), 32'(e.press));
      chk("release", 32'(release_pulse), 32'(e.rel));
      chk("repeat", 32'(repeat_pulse), 32'(e.rpt));
      chk("press_any", 32'(press_any), 32'(|e.press));
      chk("press_idx", 32'(press_idx), 32'(idx));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, cnt_p, cnt_r;
    reset = 1'b0; btn_raw = ALM; en_mask = 4'hF;
    step(); step();
    reset = 1'b1;
    step();

    // 1. clean press on channel 0
    btn_raw[0] = 1'b1;
    wait_pulse(0, 1'b0, n);
    chk("s1_latency", 32'(n), 32'd6);
    chk("s1_idx", 32'(press_idx), 32'd0);
    step();
    chk("s1_level", 32'(level[0]), 32'd1);

    // 2. bounce on channel 1
    cnt_p = 0;
    for (int k = 0; k < 8; k++) begin
      btn_raw[1] = (k % 4) < 2;
      step();
      if (press[1]) cnt_p++;
    end
    chk("s2_bounce_press", 32'(cnt_p), 32'd0);
    btn_raw[1] = 1'b1;
    wait_pulse(1, 1'b0, n);
    chk("s2_latency", 32'(n), 32'd6);

    // 3. active-low channel 3 press and release
    btn_raw[3] = 1'b0;
    wait_pulse(3, 1'b0, n);
    chk("s3_press", 32'(n), 32'd6);
    btn_raw[3] = 1'b1;
    wait_pulse(3, 1'b1, n);
    chk("s3_release", 32'(n), 32'd6);
    chk("s3_level", 32'(level[3]), 32'd0);

    btn_raw = ALM;
    repeat (10) step();

    // 4. simultaneous press with channel 2 masked
    en_mask = 4'b1011;
    btn_raw[1] = 1'b1; btn_raw[2] = 1'b1;
    wait_pulse(1, 1'b0, n);
    chk("s4_latency", 32'(n), 32'd6);
    chk("s4_press", 32'(press), 32'b0010);
    chk("s4_idx", 32'(press_idx), 32'd1);
    chk("s4_level", 32'(level[2:1]), 32'b11);
    step();
    en_mask = 4'hF;
    btn_raw = ALM;
    repeat (10) step();

    // 5. reset during debounce of channel 0
    btn_raw[0] = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("s5_outputs", 32'({level, press, release_pulse}), 32'd0);
    reset = 1'b1;
    wait_pulse(0, 1'b0, n);
    chk("s5_latency", 32'(n), 32'd6);
    btn_raw = ALM;
    repeat (10) step();

    // 6. long hold on channel 2
    btn_raw[2] = 1'b1;
    wait_pulse(2, 1'b0, n);
    chk("s6_latency", 32'(n), 32'd6);
    cnt_p = 0; cnt_r = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (press[2]) cnt_p++;
      if (repeat_pulse[2]) cnt_r++;
    end
`ifdef BTN_AUTOREPEAT_EN
    chk("s6_repeats", 32'(cnt_r), 32'd7);
    chk("s6_presses", 32'(cnt_p), 32'd7);
`else
    chk("s6_repeats", 32'(cnt_r), 32'd0);
    chk("s6_presses", 32'(cnt_p), 32'd0);
`endif
    btn_raw = ALM;
    repeat (10) step();

    // Random phase: bouncy buttons, enable changes, occasional resets
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7, 0) == 0) btn_raw[i] = ~btn_raw[i];
      if ($urandom_range(39, 0) == 0) en_mask = 4'($urandom_range(15, 0));
      reset = ($urandom_range(149, 0) != 0);
      step();
    end
    reset = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
